// File: rtl/axi_mem_buffer.sv
// rtl/axi_mem_buffer.sv - buffered AXI memory port with per-channel FIFOs and outstanding limiters

// Depth-entry register FIFO; ready is a flop so input ready never depends on output ready
module axi_mem_buffer_fifo #(
    parameter int Width = 8,
    parameter int Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [Width-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             ready_q, ready_d;
    logic             push;
    logic             pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push        = in_valid_i && ready_q;
    assign pop         = out_valid_o && out_ready_i;
    assign out_valid_o = (count_q != '0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign in_ready_o  = ready_q;

    // next occupancy, pointers and storage; ready looks at the next occupancy so a full FIFO never falls through
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
        ready_d = (count_d != CntW'(Depth));
    end

    // control state; ready held low through reset and rises on the first cycle after it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    // payload storage needs no reset; occupancy alone defines which entries are live
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end
endmodule

module axi_mem_buffer #(
    parameter int IdWidth        = 4,
    parameter int AddrWidth      = 64,
    parameter int DataWidth      = 64,
    parameter int UserWidth      = 4,
    parameter int Depth          = 2,
    parameter int MaxOutstanding = 8,
    localparam int AWW = IdWidth + AddrWidth + 35 + UserWidth,
    localparam int ARW = AWW - 6,
    localparam int WW  = DataWidth + DataWidth / 8 + 1 + UserWidth,
    localparam int BW  = IdWidth + 2 + UserWidth,
    localparam int RW  = IdWidth + DataWidth + 2 + 1 + UserWidth,
    localparam int CW  = $clog2(MaxOutstanding + 1)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [AWW-1:0] slv_aw_i,
    input  logic           slv_aw_valid_i,
    output logic           slv_aw_ready_o,
    input  logic [WW-1:0]  slv_w_i,
    input  logic           slv_w_valid_i,
    output logic           slv_w_ready_o,
    input  logic [ARW-1:0] slv_ar_i,
    input  logic           slv_ar_valid_i,
    output logic           slv_ar_ready_o,
    output logic [BW-1:0]  slv_b_o,
    output logic           slv_b_valid_o,
    input  logic           slv_b_ready_i,
    output logic [RW-1:0]  slv_r_o,
    output logic           slv_r_valid_o,
    input  logic           slv_r_ready_i,
    output logic [AWW-1:0] mst_aw_o,
    output logic           mst_aw_valid_o,
    input  logic           mst_aw_ready_i,
    output logic [WW-1:0]  mst_w_o,
    output logic           mst_w_valid_o,
    input  logic           mst_w_ready_i,
    output logic [ARW-1:0] mst_ar_o,
    output logic           mst_ar_valid_o,
    input  logic           mst_ar_ready_i,
    input  logic [BW-1:0]  mst_b_i,
    input  logic           mst_b_valid_i,
    output logic           mst_b_ready_o,
    input  logic [RW-1:0]  mst_r_i,
    input  logic           mst_r_valid_i,
    output logic           mst_r_ready_o,
    output logic [CW-1:0]  wr_outstanding_o,
    output logic [CW-1:0]  rd_outstanding_o,
    output logic           idle_o,
    output logic           err_o
);
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic          err_q, err_d;
    logic          aw_pending, ar_pending;
    logic          wr_room, rd_room;
    logic          wr_inc, wr_dec, rd_inc, rd_dec;

    assign wr_room = (wr_cnt_q < CW'(MaxOutstanding));
    assign rd_room = (rd_cnt_q < CW'(MaxOutstanding));

    axi_mem_buffer_fifo #(.Width(AWW), .Depth(Depth)) u_aw_fifo (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_data_i(slv_aw_i), .in_valid_i(slv_aw_valid_i), .in_ready_o(slv_aw_ready_o),
        .out_data_o(mst_aw_o), .out_valid_o(aw_pending), .out_ready_i(mst_aw_ready_i && wr_room)
    );

    axi_mem_buffer_fifo #(.Width(WW), .Depth(Depth)) u_w_fifo (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_data_i(slv_w_i), .in_valid_i(slv_w_valid_i), .in_ready_o(slv_w_ready_o),
        .out_data_o(mst_w_o), .out_valid_o(mst_w_valid_o), .out_ready_i(mst_w_ready_i)
    );

    axi_mem_buffer_fifo #(.Width(ARW), .Depth(Depth)) u_ar_fifo (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_data_i(slv_ar_i), .in_valid_i(slv_ar_valid_i), .in_ready_o(slv_ar_ready_o),
        .out_data_o(mst_ar_o), .out_valid_o(ar_pending), .out_ready_i(mst_ar_ready_i && rd_room)
    );

    axi_mem_buffer_fifo #(.Width(BW), .Depth(Depth)) u_b_fifo (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_data_i(mst_b_i), .in_valid_i(mst_b_valid_i), .in_ready_o(mst_b_ready_o),
        .out_data_o(slv_b_o), .out_valid_o(slv_b_valid_o), .out_ready_i(slv_b_ready_i)
    );

    axi_mem_buffer_fifo #(.Width(RW), .Depth(Depth)) u_r_fifo (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_data_i(mst_r_i), .in_valid_i(mst_r_valid_i), .in_ready_o(mst_r_ready_o),
        .out_data_o(slv_r_o), .out_valid_o(slv_r_valid_o), .out_ready_i(slv_r_ready_i)
    );

    // only the channel's own handshake can fill the counter, so a raised valid is never withdrawn
    assign mst_aw_valid_o = aw_pending && wr_room;
    assign mst_ar_valid_o = ar_pending && rd_room;

    assign wr_inc = mst_aw_valid_o && mst_aw_ready_i;
    assign wr_dec = slv_b_valid_o && slv_b_ready_i;
    assign rd_inc = mst_ar_valid_o && mst_ar_ready_i;
    assign rd_dec = slv_r_valid_o && slv_r_ready_i && slv_r_o[UserWidth];

    // outstanding counters; a completion with nothing in flight keeps the count at 0 and flags an error
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        err_d    = err_q;
        if (wr_dec && (wr_cnt_q == '0)) begin
            err_d = 1'b1;
        end
        if (rd_dec && (rd_cnt_q == '0)) begin
            err_d = 1'b1;
        end
        if (wr_inc && !wr_dec) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end else if (!wr_inc && wr_dec && (wr_cnt_q != '0)) begin
            wr_cnt_d = wr_cnt_q - 1'b1;
        end
        if (rd_inc && !rd_dec) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
        end else if (!rd_inc && rd_dec && (rd_cnt_q != '0)) begin
            rd_cnt_d = rd_cnt_q - 1'b1;
        end
    end

    // counter and sticky error state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            err_q    <= err_d;
        end
    end

    assign wr_outstanding_o = wr_cnt_q;
    assign rd_outstanding_o = rd_cnt_q;
    assign err_o            = err_q;
    assign idle_o           = !aw_pending && !mst_w_valid_o && !ar_pending && !slv_b_valid_o &&
                              !slv_r_valid_o && (wr_cnt_q == '0) && (rd_cnt_q == '0);
endmodule

// File: tb/tb_axi_mem_buffer.sv
// tb/tb_axi_mem_buffer.sv - scoreboard bench for axi_mem_buffer
module tb_axi_mem_buffer;
    localparam int IW    = 4;
    localparam int AW_W  = 64;
    localparam int DW    = 64;
    localparam int UW    = 4;
    localparam int DEPTH = 2;
    localparam int MAXO  = 2;
    localparam int AWW   = IW + AW_W + 35 + UW;
    localparam int ARW   = AWW - 6;
    localparam int WW    = DW + DW / 8 + 1 + UW;
    localparam int BW    = IW + 2 + UW;
    localparam int RW    = IW + DW + 2 + 1 + UW;
    localparam int CW    = $clog2(MAXO + 1);

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic [AWW-1:0] slv_aw_i = '0;
    logic slv_aw_valid_i = 1'b0;
    logic slv_aw_ready_o;
    logic [WW-1:0] slv_w_i = '0;
    logic slv_w_valid_i = 1'b0;
    logic slv_w_ready_o;
    logic [ARW-1:0] slv_ar_i = '0;
    logic slv_ar_valid_i = 1'b0;
    logic slv_ar_ready_o;
    logic [BW-1:0] slv_b_o;
    logic slv_b_valid_o;
    logic slv_b_ready_i = 1'b1;
    logic [RW-1:0] slv_r_o;
    logic slv_r_valid_o;
    logic slv_r_ready_i = 1'b1;
    logic [AWW-1:0] mst_aw_o;
    logic mst_aw_valid_o;
    logic mst_aw_ready_i = 1'b1;
    logic [WW-1:0] mst_w_o;
    logic mst_w_valid_o;
    logic mst_w_ready_i = 1'b1;
    logic [ARW-1:0] mst_ar_o;
    logic mst_ar_valid_o;
    logic mst_ar_ready_i = 1'b1;
    logic [BW-1:0] mst_b_i = '0;
    logic mst_b_valid_i = 1'b0;
    logic mst_b_ready_o;
    logic [RW-1:0] mst_r_i = '0;
    logic mst_r_valid_i = 1'b0;
    logic mst_r_ready_o;
    logic [CW-1:0] wr_outstanding_o;
    logic [CW-1:0] rd_outstanding_o;
    logic idle_o;
    logic err_o;

    axi_mem_buffer #(
        .IdWidth(IW), .AddrWidth(AW_W), .DataWidth(DW), .UserWidth(UW),
        .Depth(DEPTH), .MaxOutstanding(MAXO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .slv_aw_i(slv_aw_i), .slv_aw_valid_i(slv_aw_valid_i), .slv_aw_ready_o(slv_aw_ready_o),
        .slv_w_i(slv_w_i), .slv_w_valid_i(slv_w_valid_i), .slv_w_ready_o(slv_w_ready_o),
        .slv_ar_i(slv_ar_i), .slv_ar_valid_i(slv_ar_valid_i), .slv_ar_ready_o(slv_ar_ready_o),
        .slv_b_o(slv_b_o), .slv_b_valid_o(slv_b_valid_o), .slv_b_ready_i(slv_b_ready_i),
        .slv_r_o(slv_r_o), .slv_r_valid_o(slv_r_valid_o), .slv_r_ready_i(slv_r_ready_i),
        .mst_aw_o(mst_aw_o), .mst_aw_valid_o(mst_aw_valid_o), .mst_aw_ready_i(mst_aw_ready_i),
        .mst_w_o(mst_w_o), .mst_w_valid_o(mst_w_valid_o), .mst_w_ready_i(mst_w_ready_i),
        .mst_ar_o(mst_ar_o), .mst_ar_valid_o(mst_ar_valid_o), .mst_ar_ready_i(mst_ar_ready_i),
        .mst_b_i(mst_b_i), .mst_b_valid_i(mst_b_valid_i), .mst_b_ready_o(mst_b_ready_o),
        .mst_r_i(mst_r_i), .mst_r_valid_i(mst_r_valid_i), .mst_r_ready_o(mst_r_ready_o),
        .wr_outstanding_o(wr_outstanding_o), .rd_outstanding_o(rd_outstanding_o),
        .idle_o(idle_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // reference model: per-channel ordered queues, in-flight counts, sticky error
    logic [AWW-1:0] aw_q[$];
    logic [WW-1:0]  w_q[$];
    logic [ARW-1:0] ar_q[$];
    logic [BW-1:0]  b_q[$];
    logic [RW-1:0]  r_q[$];
    int  wr_cnt = 0;
    int  rd_cnt = 0;
    bit  err_m = 1'b0;
    bit  last_rst = 1'b1;
    int  w_push_cnt = 0;
    int  r_pop_cnt = 0;
    bit  e_aw_rdy, e_w_rdy, e_ar_rdy, e_b_rdy, e_r_rdy;
    bit  e_aw_v, e_w_v, e_ar_v, e_b_v, e_r_v, e_idle;
    bit  wr_inc, wr_dec, rd_inc, rd_dec;

    // monitor: compare DUT against model between edges, then advance model by the coming edge
    always @(negedge clk_i) begin
        e_aw_rdy = !last_rst && (aw_q.size() < DEPTH);
        e_w_rdy  = !last_rst && (w_q.size() < DEPTH);
        e_ar_rdy = !last_rst && (ar_q.size() < DEPTH);
        e_b_rdy  = !last_rst && (b_q.size() < DEPTH);
        e_r_rdy  = !last_rst && (r_q.size() < DEPTH);
        e_aw_v   = (aw_q.size() > 0) && (wr_cnt < MAXO);
        e_ar_v   = (ar_q.size() > 0) && (rd_cnt < MAXO);
        e_w_v    = (w_q.size() > 0);
        e_b_v    = (b_q.size() > 0);
        e_r_v    = (r_q.size() > 0);
        e_idle   = (aw_q.size() == 0) && (w_q.size() == 0) && (ar_q.size() == 0) &&
                   (b_q.size() == 0) && (r_q.size() == 0) && (wr_cnt == 0) && (rd_cnt == 0);

        check("slv_aw_ready", 128'(slv_aw_ready_o), 128'(e_aw_rdy));
        check("slv_w_ready", 128'(slv_w_ready_o), 128'(e_w_rdy));
        check("slv_ar_ready", 128'(slv_ar_ready_o), 128'(e_ar_rdy));
        check("mst_b_ready", 128'(mst_b_ready_o), 128'(e_b_rdy));
        check("mst_r_ready", 128'(mst_r_ready_o), 128'(e_r_rdy));
        check("mst_aw_valid", 128'(mst_aw_valid_o), 128'(e_aw_v));
        check("mst_w_valid", 128'(mst_w_valid_o), 128'(e_w_v));
        check("mst_ar_valid", 128'(mst_ar_valid_o), 128'(e_ar_v));
        check("slv_b_valid", 128'(slv_b_valid_o), 128'(e_b_v));
        check("slv_r_valid", 128'(slv_r_valid_o), 128'(e_r_v));
        if (e_aw_v) check("mst_aw_data", 128'(mst_aw_o), 128'(aw_q[0]));
        if (e_w_v)  check("mst_w_data", 128'(mst_w_o), 128'(w_q[0]));
        if (e_ar_v) check("mst_ar_data", 128'(mst_ar_o), 128'(ar_q[0]));
        if (e_b_v)  check("slv_b_data", 128'(slv_b_o), 128'(b_q[0]));
        if (e_r_v)  check("slv_r_data", 128'(slv_r_o), 128'(r_q[0]));
        check("wr_outstanding", 128'(wr_outstanding_o), 128'(wr_cnt));
        check("rd_outstanding", 128'(rd_outstanding_o), 128'(rd_cnt));
        check("idle", 128'(idle_o), 128'(e_idle));
        check("err", 128'(err_o), 128'(err_m));

        if (rst_i) begin
            aw_q.delete(); w_q.delete(); ar_q.delete(); b_q.delete(); r_q.delete();
            wr_cnt = 0;
            rd_cnt = 0;
            err_m  = 1'b0;
        end else begin
            wr_inc = e_aw_v && mst_aw_ready_i;
            rd_inc = e_ar_v && mst_ar_ready_i;
            wr_dec = e_b_v && slv_b_ready_i;
            rd_dec = e_r_v && slv_r_ready_i && r_q[0][UW];
            if (wr_inc) void'(aw_q.pop_front());
            if (rd_inc) void'(ar_q.pop_front());
            if (e_w_v && mst_w_ready_i) void'(w_q.pop_front());
            if (wr_dec) void'(b_q.pop_front());
            if (e_r_v && slv_r_ready_i) begin
                void'(r_q.pop_front());
                r_pop_cnt++;
            end
            if (slv_aw_valid_i && e_aw_rdy) aw_q.push_back(slv_aw_i);
            if (slv_w_valid_i && e_w_rdy) begin
                w_q.push_back(slv_w_i);
                w_push_cnt++;
            end
            if (slv_ar_valid_i && e_ar_rdy) ar_q.push_back(slv_ar_i);
            if (mst_b_valid_i && e_b_rdy) b_q.push_back(mst_b_i);
            if (mst_r_valid_i && e_r_rdy) r_q.push_back(mst_r_i);
            if (wr_dec && wr_cnt == 0) err_m = 1'b1;
            if (rd_dec && rd_cnt == 0) err_m = 1'b1;
            wr_cnt = wr_cnt + (wr_inc ? 1 : 0) - ((wr_dec && (wr_cnt > 0 || wr_inc)) ? 1 : 0);
            rd_cnt = rd_cnt + (rd_inc ? 1 : 0) - ((rd_dec && (rd_cnt > 0 || rd_inc)) ? 1 : 0);
        end
        last_rst = rst_i;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    logic [127:0] tmp;
    int base;
    int n;

    initial begin
        steps(3);
        rst_i = 1'b0;
        step();

        // single write with okay response
        slv_aw_i = {4'd3, 64'h8000_0000, 8'd0, 3'd3, 2'd1, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 6'd0, 4'd0};
        slv_aw_valid_i = 1'b1;
        slv_w_i = {64'hDEAD_BEEF, 8'hFF, 1'b1, 4'd0};
        slv_w_valid_i = 1'b1;
        step();
        slv_aw_valid_i = 1'b0;
        slv_w_valid_i = 1'b0;
        check("aw_issue_one_cycle", 128'(mst_aw_valid_o), 128'(1));
        step();
        check("wr_out_after_issue", 128'(wr_outstanding_o), 128'(1));
        mst_b_i = {4'd3, 2'd0, 4'd0};
        mst_b_valid_i = 1'b1;
        step();
        mst_b_valid_i = 1'b0;
        check("b_valid", 128'(slv_b_valid_o), 128'(1));
        check("b_id", 128'(slv_b_o[BW-1 -: IW]), 128'(3));
        check("b_resp", 128'(slv_b_o[UW+1 -: 2]), 128'(0));
        step();
        check("wr_out_after_b", 128'(wr_outstanding_o), 128'(0));
        check("idle_after_write", 128'(idle_o), 128'(1));

        // read limiter with memory holding R back
        for (int i = 0; i < 4; i++) begin
            tmp = rnd();
            slv_ar_i = {4'(i), tmp[ARW-IW-1:0]};
            slv_ar_valid_i = 1'b1;
            n = 0;
            while (!slv_ar_ready_o && n < 20) begin
                step();
                n++;
            end
            check("ar_ready_wait", 128'(n < 20), 128'(1));
            step();
        end
        slv_ar_valid_i = 1'b0;
        steps(3);
        check("rd_out_limited", 128'(rd_outstanding_o), 128'(MAXO));
        check("ar_fifo_full", 128'(slv_ar_ready_o), 128'(0));
        check("ar_throttled", 128'(mst_ar_valid_o), 128'(0));
        mst_r_i = {4'd0, 64'h0, 2'd0, 1'b1, 4'd0};
        mst_r_valid_i = 1'b1;
        step();
        mst_r_valid_i = 1'b0;
        step();
        check("third_ar_issues", 128'(mst_ar_valid_o), 128'(1));
        for (int i = 1; i < 4; i++) begin
            mst_r_i = {4'(i), 64'h0, 2'd0, 1'b1, 4'd0};
            mst_r_valid_i = 1'b1;
            step();
            mst_r_valid_i = 1'b0;
            steps(2);
        end
        steps(3);
        check("rd_out_drained", 128'(rd_outstanding_o), 128'(0));

        // W backpressure
        mst_w_ready_i = 1'b0;
        base = w_push_cnt;
        for (int i = 0; i < 5; i++) begin
            tmp = rnd();
            slv_w_i = tmp[WW-1:0];
            slv_w_valid_i = 1'b1;
            step();
        end
        check("w_accepted_when_blocked", 128'(w_push_cnt - base), 128'(DEPTH));
        check("w_ready_low_full", 128'(slv_w_ready_o), 128'(0));
        slv_w_valid_i = 1'b0;
        mst_w_ready_i = 1'b1;
        steps(4);

        // B completion and AW issue on the same edge at MaxOutstanding-1
        slv_aw_i = rnd();
        slv_aw_valid_i = 1'b1;
        step();
        slv_aw_valid_i = 1'b0;
        steps(2);
        check("wr_out_one", 128'(wr_outstanding_o), 128'(MAXO - 1));
        slv_aw_i = rnd();
        slv_aw_valid_i = 1'b1;
        mst_b_i = {4'd1, 2'd0, 4'd0};
        mst_b_valid_i = 1'b1;
        step();
        slv_aw_valid_i = 1'b0;
        mst_b_valid_i = 1'b0;
        check("aw_no_stall", 128'(mst_aw_valid_o), 128'(1));
        step();
        check("wr_out_unchanged", 128'(wr_outstanding_o), 128'(MAXO - 1));
        mst_b_valid_i = 1'b1;
        step();
        mst_b_valid_i = 1'b0;
        steps(2);

        // spurious B with nothing in flight
        mst_b_i = {4'd9, 2'd2, 4'd5};
        mst_b_valid_i = 1'b1;
        step();
        mst_b_valid_i = 1'b0;
        step();
        check("spurious_err", 128'(err_o), 128'(1));
        check("spurious_cnt", 128'(wr_outstanding_o), 128'(0));
        steps(3);
        check("err_sticky", 128'(err_o), 128'(1));
        rst_i = 1'b1;
        step();
        check("err_cleared", 128'(err_o), 128'(0));
        rst_i = 1'b0;
        step();

        // reset in the middle of a 4-beat R burst
        tmp = rnd();
        slv_ar_i = tmp[ARW-1:0];
        slv_ar_valid_i = 1'b1;
        step();
        slv_ar_valid_i = 1'b0;
        step();
        base = r_pop_cnt;
        for (int b = 0; b < 4; b++) begin
            tmp = rnd();
            mst_r_i = {tmp[RW-1:UW+1], 1'(b == 3), tmp[UW-1:0]};
            mst_r_valid_i = 1'b1;
            step();
            if (r_pop_cnt - base >= 2) break;
        end
        rst_i = 1'b1;
        mst_r_valid_i = 1'b0;
        step();
        check("rst_r_valid", 128'(slv_r_valid_o), 128'(0));
        check("rst_rd_out", 128'(rd_outstanding_o), 128'(0));
        check("rst_idle", 128'(idle_o), 128'(1));
        rst_i = 1'b0;
        steps(3);
        check("no_r_after_rst", 128'(slv_r_valid_o), 128'(0));

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst_i = ($urandom_range(0, 399) == 0);
            slv_aw_i = rnd();
            tmp = rnd(); slv_w_i = tmp[WW-1:0];
            tmp = rnd(); slv_ar_i = tmp[ARW-1:0];
            tmp = rnd(); mst_b_i = tmp[BW-1:0];
            tmp = rnd(); mst_r_i = tmp[RW-1:0];
            slv_aw_valid_i = ($urandom_range(0, 2) == 0);
            slv_w_valid_i  = ($urandom_range(0, 1) == 0);
            slv_ar_valid_i = ($urandom_range(0, 2) == 0);
            mst_b_valid_i  = ($urandom_range(0, 3) == 0);
            mst_r_valid_i  = ($urandom_range(0, 1) == 0);
            mst_aw_ready_i = ($urandom_range(0, 3) != 0);
            mst_w_ready_i  = ($urandom_range(0, 3) != 0);
            mst_ar_ready_i = ($urandom_range(0, 3) != 0);
            slv_b_ready_i  = ($urandom_range(0, 3) != 0);
            slv_r_ready_i  = ($urandom_range(0, 3) != 0);
            step();
        end
        slv_aw_valid_i = 1'b0;
        slv_w_valid_i = 1'b0;
        slv_ar_valid_i = 1'b0;
        mst_b_valid_i = 1'b0;
        mst_r_valid_i = 1'b0;
        rst_i = 1'b1;
        steps(2);
        rst_i = 1'b0;
        steps(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
